mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage: byte-addressed big-endian data RAM plus load formatting and the
//  ALU-vs-load result mux. Sits between EX/MEM and MEM/WB; mem_mux_out feeds the
//  MEM/WB register directly. Stores commit on clk; loads are combinational in-cycle.
// PARAMETERS
//  ADDR_W   9   byte-address width; RAM depth = 2**ADDR_W bytes (512)
// PORTS
//  clk            in   1       clock, all state updates on posedge
//  reset          in   1       synchronous, active-high
//  alu_result     in   32      effective address / non-load result
//  store_data     in   32      rt value for SB/SH/SW
//  mem_read       in   1       load in this cycle
//  mem_write      in   1       store in this cycle
//  mem_size       in   2       00 byte, 01 half, 10 word, 11 reserved
//  mem_signed     in   1       1 = sign-extend byte/half load (LB/LH), 0 = zero (LBU/LHU)
//  mem_to_reg     in   1       1 = select load_data onto mem_mux_out
//  preload_en     in   1       bench/loader byte write enable
//  preload_addr   in   ADDR_W  loader byte address
//  preload_byte   in   8       loader byte value
//  load_data      out  32      formatted load value (comb)
//  mem_mux_out    out  32      mem_to_reg ? load_data : alu_result (comb)
//  misalign       out  1       current access misaligned (comb)
//  misalign_sticky out 1       registered OR of misalign since last reset
// BEHAVIOUR
//  - addr = alu_result[ADDR_W-1:0]; upper bits ignored (address wraps modulo depth).
//  - Big-endian: word at A = {M[A],M[A+1],M[A+2],M[A+3]}; half = {M[A],M[A+1]}.
//  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0; only when mem_read|mem_write.
//    Misaligned store: no RAM write. Misaligned load: load_data = 0. misalign = 1.
//  - mem_size=11: no access, load_data = 0, store dropped, misalign = 0.
//  - Store (posedge, mem_write & aligned & !reset): SB writes store_data[7:0] to M[A];
//    SH writes [15:8],[7:0] to A,A+1; SW writes [31:24]..[7:0] to A..A+3.
//  - Load: byte/half extended per mem_signed; word passed unchanged. mem_read=0 -> load_data=0.
//  - mem_read & mem_write together: store commits at edge; load shows pre-store contents.
//  - Read-during-write same address: old data this cycle, new data from next cycle.
//  - preload_en & mem_write same cycle: preload commits, store dropped entirely
//    (no partial bytes), even if addresses differ.
//  - Reset: misalign_sticky <= 0; RAM contents NOT cleared; stores and preloads
//    suppressed while reset=1. Comb outputs stay valid during reset.
//  - misalign_sticky <= misalign_sticky | misalign each non-reset cycle (1-cycle latency).
//  - Latency: load/mux outputs 0 cycles; store visible to loads 1 cycle after edge.
// STRUCTURE
//  - Package mips_mem_pkg: MEM_SZ_BYTE/HALF/WORD/RSVD localparams, helper
//    function is_misaligned(size, addr[1:0]).
//  - Sub-module mem_load_align: pure comb; takes 4 raw bytes at A..A+3, size,
//    signed, addr[1:0] -> formatted 32-bit load value. RAM, store byte-enables,
//    collision logic and sticky flag stay in mem_access_stage.
// TESTING
//  1. Preload 11,22,33,44 at 0..3; LW addr 0, mem_to_reg=1 -> mem_mux_out=0x11223344.
//  2. Preload 0x80 at 5; LB addr 5 -> 0xFFFFFF80; LBU addr 5 -> 0x00000080;
//     mem_to_reg=0 -> mem_mux_out = alu_result.
//  3. SH 0xABCDBEEF at 8, then LW 8 (M[10..11] preloaded 0) -> 0xBEEF0000;
//     LH 8 signed -> 0xFFFFBEEF.
//  4. SW 0xDEADBEEF at addr 2 -> misalign=1, LW 0 unchanged 0x11223344,
//     misalign_sticky=1 next cycle; reset -> sticky=0, LW 0 still 0x11223344.
//  5. Same cycle preload 0x55 at 20 and SW 0xCAFEF00D at 16 -> M[20]=0x55,
//     LW 16 returns prior contents (store dropped).
//  6. SW 0x01020304 at alu_result=0x200 (ADDR_W=9) -> lands at 0; LW 0 = 0x01020304.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared size encodings and alignment helper for the MEM stage.
package mips_mem_pkg;
    localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
    localparam logic [1:0] MEM_SZ_HALF = 2'b01;
    localparam logic [1:0] MEM_SZ_WORD = 2'b10;
    localparam logic [1:0] MEM_SZ_RSVD = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == MEM_SZ_HALF && a[0]) || (size == MEM_SZ_WORD && a != 2'b00);
    endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: formats four big-endian raw bytes at A..A+3 into a load value.
module mem_load_align import mips_mem_pkg::*; (
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  logic [7:0]  b3,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);
    always_comb begin
        data = is_misaligned(size, addr_lo) ? 32'h0 :
               size == MEM_SZ_BYTE ? {{24{sgn & b0[7]}}, b0} :
               size == MEM_SZ_HALF ? {{16{sgn & b0[7]}}, b0, b1} :
               size == MEM_SZ_WORD ? {b0, b1, b2, b3} : 32'h0;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with big-endian byte RAM, load formatting
// and the ALU-vs-load writeback mux.
module mem_access_stage import mips_mem_pkg::*; #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic              mem_to_reg,
    input  logic              preload_en,
    input  logic [ADDR_W-1:0] preload_addr,
    input  logic [7:0]        preload_byte,
    output logic [31:0]       load_data,
    output logic [31:0]       mem_mux_out,
    output logic              misalign,
    output logic              misalign_sticky
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] lane_addr [4];
    logic [7:0]        lane_byte [4];
    logic [3:0]        be;
    logic [31:0]       wd;
    logic [31:0]       align_data;
    logic              store_ok;
    logic              sticky_d, sticky_q;

    always_comb begin
        addr = alu_result[ADDR_W-1:0];
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = addr + ADDR_W'(k);
            lane_byte[k] = mem_q[lane_addr[k]];
        end
        misalign = (mem_read | mem_write) & is_misaligned(mem_size, addr[1:0]);
        // a concurrent preload wins and the whole store is dropped
        store_ok = mem_write & ~misalign & ~preload_en & ~reset;
        be = !store_ok ? 4'b0000 :
             mem_size == MEM_SZ_BYTE ? 4'b0001 :
             mem_size == MEM_SZ_HALF ? 4'b0011 :
             mem_size == MEM_SZ_WORD ? 4'b1111 : 4'b0000;
        // left-justify the store so lane k always takes byte 3-k
        wd = mem_size == MEM_SZ_BYTE ? {store_data[7:0], 24'h0} :
             mem_size == MEM_SZ_HALF ? {store_data[15:0], 16'h0} : store_data;
        load_data = mem_read ? align_data : 32'h0;
        mem_mux_out = mem_to_reg ? load_data : alu_result;
        sticky_d = sticky_q | misalign;
    end

    always_ff @(posedge clk) begin
        sticky_q <= reset ? 1'b0 : sticky_d;
        for (int k = 0; k < 4; k++)
            if (be[k]) mem_q[lane_addr[k]] <= wd[31-8*k -: 8];
        if (preload_en && !reset) mem_q[preload_addr] <= preload_byte;
    end

    assign misalign_sticky = sticky_q;

    mem_load_align u_align (
        .b0      (lane_byte[0]),
        .b1      (lane_byte[1]),
        .b2      (lane_byte[2]),
        .b3      (lane_byte[3]),
        .size    (mem_size),
        .sgn     (mem_signed),
        .addr_lo (addr[1:0]),
        .data    (align_data)
    );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scoreboard bench for mem_access_stage.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result, store_data;
    logic        mem_read, mem_write, mem_signed, mem_to_reg, preload_en;
    logic [1:0]  mem_size;
    logic [8:0]  preload_addr;
    logic [7:0]  preload_byte;
    logic [31:0] load_data, mem_mux_out;
    logic        misalign, misalign_sticky;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(9)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_result      (alu_result),
        .store_data      (store_data),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_size        (mem_size),
        .mem_signed      (mem_signed),
        .mem_to_reg      (mem_to_reg),
        .preload_en      (preload_en),
        .preload_addr    (preload_addr),
        .preload_byte    (preload_byte),
        .load_data       (load_data),
        .mem_mux_out     (mem_mux_out),
        .misalign        (misalign),
        .misalign_sticky (misalign_sticky)
    );

    function automatic logic [31:0] obs(input int sel);
        return sel == 0 ? load_data : sel == 1 ? mem_mux_out :
               sel == 2 ? {31'h0, misalign} : {31'h0, misalign_sticky};
    endfunction

    task automatic go();
        @(negedge clk);
    endtask

    task automatic idle();
        mem_read = 0; mem_write = 0; mem_size = 2'b10; mem_signed = 0; mem_to_reg = 0;
        preload_en = 0; preload_addr = '0; preload_byte = '0;
        alu_result = '0; store_data = '0;
    endtask

    task automatic acc(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic m2r, input logic [31:0] alu, input logic [31:0] sd);
        mem_read = rd; mem_write = wr; mem_size = sz; mem_signed = sg;
        mem_to_reg = m2r; alu_result = alu; store_data = sd;
    endtask

    task automatic pre(input logic [8:0] a, input logic [7:0] b);
        idle();
        preload_en = 1; preload_addr = a; preload_byte = b;
        go();
        preload_en = 0;
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (obs(e.sel) === e.exp)
            else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs(e.sel), e.exp);
            end
        end
    endtask

    initial begin
        idle();
        reset = 1;
        go(); go();
        expect_val("reset_sticky", 3, 0);
        drain();
        reset = 0;

        // 1: big-endian word and sub-word loads
        pre(0, 8'h11); pre(1, 8'h22); pre(2, 8'h33); pre(3, 8'h44);
        acc(1, 0, 2'b10, 0, 1, 0, 0);
        expect_val("lw0_mux", 1, 32'h11223344);
        expect_val("lw0_ld", 0, 32'h11223344);
        expect_val("lw0_mis", 2, 0);
        drain(); go();
        acc(1, 0, 2'b01, 0, 1, 2, 0);
        expect_val("lhu2", 0, 32'h00003344);
        drain(); go();
        acc(1, 0, 2'b00, 1, 1, 3, 0);
        expect_val("lb3", 0, 32'h00000044);
        drain(); go();

        // 2: sign/zero extension and mux select
        pre(5, 8'h80);
        acc(1, 0, 2'b00, 1, 1, 5, 0);
        expect_val("lb5", 1, 32'hFFFFFF80);
        drain(); go();
        acc(1, 0, 2'b00, 0, 1, 5, 0);
        expect_val("lbu5", 1, 32'h00000080);
        drain(); go();
        acc(1, 0, 2'b00, 1, 0, 5, 0);
        expect_val("mux_alu", 1, 32'h00000005);
        drain(); go();
        acc(0, 0, 2'b10, 0, 1, 0, 0);
        expect_val("noread_ld", 0, 0);
        drain(); go();

        // 3: SH with read-during-write, then reloads
        pre(8, 0); pre(9, 0); pre(10, 0); pre(11, 0);
        acc(1, 1, 2'b01, 0, 1, 8, 32'hABCDBEEF);
        expect_val("sh_rdw_old", 0, 32'h00000000);
        drain(); go();
        acc(1, 0, 2'b10, 0, 1, 8, 0);
        expect_val("lw8", 0, 32'hBEEF0000);
        drain(); go();
        acc(1, 0, 2'b01, 1, 1, 8, 0);
        expect_val("lh8", 0, 32'hFFFFBEEF);
        drain(); go();

        // 4: misaligned store, misaligned/reserved loads, sticky and reset
        acc(0, 1, 2'b10, 0, 0, 2, 32'hDEADBEEF);
        expect_val("sw2_mis", 2, 1);
        expect_val("sticky_pre", 3, 0);
        drain(); go();
        acc(1, 0, 2'b10, 0, 1, 0, 0);
        expect_val("lw0_after_mis", 0, 32'h11223344);
        expect_val("sticky_set", 3, 1);
        drain(); go();
        acc(1, 0, 2'b10, 0, 1, 1, 0);
        expect_val("lw1_mis", 2, 1);
        expect_val("lw1_zero", 0, 0);
        drain(); go();
        acc(1, 0, 2'b01, 1, 1, 1, 0);
        expect_val("lh1_mis", 2, 1);
        drain(); go();
        acc(1, 1, 2'b11, 0, 1, 1, 32'hFFFFFFFF);
        expect_val("rsvd_mis", 2, 0);
        expect_val("rsvd_ld", 0, 0);
        drain(); go();
        acc(0, 1, 2'b11, 0, 0, 0, 0);
        drain(); go();
        acc(1, 0, 2'b10, 0, 1, 0, 0);
        expect_val("rsvd_st_drop", 0, 32'h11223344);
        drain(); go();
        reset = 1;
        preload_en = 1; preload_addr = 1; preload_byte = 8'h77;
        acc(1, 1, 2'b10, 0, 1, 0, 32'hFFFFFFFF);
        expect_val("rst_comb_ld", 1, 32'h11223344);
        drain(); go();
        idle();
        acc(1, 0, 2'b10, 0, 1, 0, 0);
        expect_val("rst_sticky_clr", 3, 0);
        drain(); go();
        reset = 0;
        expect_val("rst_ram_kept", 0, 32'h11223344);
        drain(); go();

        // 5: preload and store in the same cycle
        pre(16, 8'hA1); pre(17, 8'hA2); pre(18, 8'hA3); pre(19, 8'hA4); pre(20, 0);
        preload_en = 1; preload_addr = 20; preload_byte = 8'h55;
        acc(0, 1, 2'b10, 0, 0, 16, 32'hCAFEF00D);
        go();
        idle();
        acc(1, 0, 2'b10, 0, 1, 16, 0);
        expect_val("sw_dropped", 0, 32'hA1A2A3A4);
        drain(); go();
        acc(1, 0, 2'b00, 0, 1, 20, 0);
        expect_val("preload_won", 0, 32'h00000055);
        drain(); go();

        // 6: address wraps modulo depth
        acc(0, 1, 2'b10, 0, 0, 32'h200, 32'h01020304);
        go();
        acc(1, 0, 2'b10, 0, 1, 0, 0);
        expect_val("wrap_lw0", 0, 32'h01020304);
        drain(); go();
        acc(1, 0, 2'b10, 0, 1, 32'h1000, 0);
        expect_val("wrap_hi", 1, 32'h01020304);
        drain(); go();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
